dvi_timing_ctrl: RTL
====================

Name: dvi_timing_ctrl

Overview:
- Video timing controller that sequences the DVI output path.
- Generates fetch requests (x, y) toward the pixel source a fixed latency ahead of display, then emits latency-aligned vsync/hsync/den/r/g/b in the pixel clock domain, ready to drive the TMDS encoder/serialiser front end.
- Provides frame/line/vblank status for framebuffer sequencing.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (cycles)
H_SYNC, 96, hsync width (cycles)
H_BP, 48, horizontal back porch (cycles)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
H_SYNC_POL, 0, asserted level of hsync (0 = active-low)
V_SYNC_POL, 0, asserted level of vsync
FETCH_LAT, 2, cycles from fetch_req to pix_* valid (0..8)
RGB_BITS, 6, colour channel width
X_BITS, 11, width of fetch_x
Y_BITS, 10, width of fetch_y

Ports:
clk_pix  in  1  pixel clock
rst_pix  in  1  synchronous active-high reset
en  in  1  timing run enable
fetch_req  out  1  pixel request for (fetch_x, fetch_y)
fetch_x  out  X_BITS  requested column
fetch_y  out  Y_BITS  requested line
pix_r/pix_g/pix_b  in  RGB_BITS each  returned pixel, valid FETCH_LAT cycles after fetch_req
frame_start  out  1  one-cycle pulse with fetch of (0,0)
line_start  out  1  one-cycle pulse with fetch of (0,y), y<V_ACTIVE
vblank  out  1  fetch-domain v_cnt >= V_ACTIVE
vsync, hsync, den  out  1 each  display timing to encoder
r, g, b  out  RGB_BITS each  display pixel

Behaviour:
- Clock is clk_pix; reset is rst_pix, synchronous and active-high.
- Counters:
  - h_cnt 0..H_TOTAL-1 (H_TOTAL = sum of H_*), v_cnt 0..V_TOTAL-1.
  - h_cnt wraps to 0 and v_cnt increments; v_cnt wraps to 0 after V_TOTAL-1 at the h wrap.
- Line order: active, front porch, sync, back porch. Same order vertically.
- Fetch stage (registered, 1 cycle after counter state):
  - fetch_req = en & h_cnt<H_ACTIVE & v_cnt<V_ACTIVE.
  - fetch_x = h_cnt, fetch_y = v_cnt, zero when fetch_req=0.
  - frame_start = fetch_req & h=0 & v=0; line_start = fetch_req & h=0.
- Display pipeline:
  - A den/hsync/vsync shift register aligns control with data.
  - Pixel requested with fetch_req high at cycle c is sampled from pix_* at the edge ending cycle c+FETCH_LAT.
  - The pixel appears on r/g/b with den=1 at cycle c+FETCH_LAT+1. Total fetch-to-display latency is FETCH_LAT+1 cycles.
  - hsync is asserted (=H_SYNC_POL) for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync is asserted (=V_SYNC_POL) for whole lines with v_cnt in the vsync region, changing at the h wrap.
  - Both carry the same FETCH_LAT+1 delay as den.
  - r/g/b = pix_* when the aligned den=1, else forced 0. pix_* is ignored during blanking.
- Reset values (cycle after rst_pix sampled high):
  - h_cnt = v_cnt = 0; pipeline cleared.
  - fetch_req, fetch_x, fetch_y, frame_start, line_start, den, r, g, b = 0.
  - vblank = 0.
  - hsync = ~H_SYNC_POL, vsync = ~V_SYNC_POL.
- Enable:
  - en=0 holds h_cnt/v_cnt at 0 and forces fetch-stage outputs and vblank to 0.
  - The pipeline keeps shifting, filling with deasserted values. After FETCH_LAT+1 cycles all display outputs are at reset values.
  - en 0→1: counting begins from (0,0); frame_start pulses on the first fetch cycle.
  - en 1→0 mid-frame: counters clear that cycle. Pixels already in flight still emerge with den=1. No partial-frame resume.
- Reset mid-frame overrides en and clears the pipeline immediately; no in-flight pixels are emitted.
- All outputs are registered; no combinational input-to-output paths.

Test Plan:
- Reset: hold rst_pix with en=1 and random pix_* -> all outputs at reset values; hsync=vsync=1 for POL=0.
- Small frame (H 4/1/2/1, V 3/1/1/1, FETCH_LAT=0), en=1 for 96 cycles:
  - frame period 48 cycles; 12 fetch_req and 12 den cycles per frame.
  - hsync low 2 of every 8 cycles; vsync low 8 consecutive cycles.
  - frame_start once per 48 cycles.
- Latency with FETCH_LAT=2:
  - model returns pix_r = fetch_x at c+2.
  - den rises exactly 3 cycles after the first fetch_req.
  - r sequence reads 0,1,2,3 per line.
  - hsync edge is 3 cycles after the fetch-domain h_cnt reaches 5.
- Blanking: drive pix_*=all-ones constantly -> r/g/b=0 whenever den=0, all-ones whenever den=1.
- en drop at fetch (2,1), then re-raise:
  - counters reset to 0.
  - in-flight pixels emerge, then den stays 0.
  - after re-raise, next fetch is (0,0) with frame_start=1.
- rst_pix pulse mid-active-line with FETCH_LAT=2: den=0 on the following cycle; first post-reset fetch is (0,0); H_SYNC_POL=1 variant inverts hsync only.

Source files
------------

// File: rtl/dvi_timing_ctrl.sv
// DVI video timing controller: raster counters, fetch-ahead request stage and a
// latency-matched display stage producing vsync/hsync/den/rgb for the TMDS path.
module dvi_timing_ctrl #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int H_SYNC_POL = 0,
  parameter int V_SYNC_POL = 0,
  parameter int FETCH_LAT  = 2,
  parameter int RGB_BITS   = 6,
  parameter int X_BITS     = 11,
  parameter int Y_BITS     = 10
) (
  input  logic                clk_pix,
  input  logic                rst_pix,
  input  logic                en,
  output logic                fetch_req,
  output logic [X_BITS-1:0]   fetch_x,
  output logic [Y_BITS-1:0]   fetch_y,
  input  logic [RGB_BITS-1:0] pix_r,
  input  logic [RGB_BITS-1:0] pix_g,
  input  logic [RGB_BITS-1:0] pix_b,
  output logic                frame_start,
  output logic                line_start,
  output logic                vblank,
  output logic                vsync,
  output logic                hsync,
  output logic                den,
  output logic [RGB_BITS-1:0] r,
  output logic [RGB_BITS-1:0] g,
  output logic [RGB_BITS-1:0] b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [X_BITS-1:0] H_ACT_L  = X_BITS'(H_ACTIVE);
  localparam logic [X_BITS-1:0] H_SS_L   = X_BITS'(H_ACTIVE + H_FP);
  localparam logic [X_BITS-1:0] H_SE_L   = X_BITS'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [X_BITS-1:0] H_LAST_L = X_BITS'(H_TOTAL - 1);
  localparam logic [Y_BITS-1:0] V_ACT_L  = Y_BITS'(V_ACTIVE);
  localparam logic [Y_BITS-1:0] V_SS_L   = Y_BITS'(V_ACTIVE + V_FP);
  localparam logic [Y_BITS-1:0] V_SE_L   = Y_BITS'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [Y_BITS-1:0] V_LAST_L = Y_BITS'(V_TOTAL - 1);
  localparam logic              H_POL    = 1'(H_SYNC_POL);
  localparam logic              V_POL    = 1'(V_SYNC_POL);

  // Control flags travel as "asserted" bits; polarity is applied only at the output.
  typedef struct packed {
    logic den;
    logic hs;
    logic vs;
  } ctl_t;

  logic [X_BITS-1:0]   h_q, h_d;
  logic [Y_BITS-1:0]   v_q, v_d;
  logic                fetch_req_q, fetch_req_d;
  logic [X_BITS-1:0]   fetch_x_q, fetch_x_d;
  logic [Y_BITS-1:0]   fetch_y_q, fetch_y_d;
  logic                frame_start_q, frame_start_d;
  logic                line_start_q, line_start_d;
  logic                vblank_q, vblank_d;
  ctl_t                ctl_q [0:FETCH_LAT];
  ctl_t                ctl_d [0:FETCH_LAT];
  ctl_t                tap;
  logic                active;
  logic                den_q, den_d;
  logic                hsync_q, hsync_d;
  logic                vsync_q, vsync_d;
  logic [RGB_BITS-1:0] r_q, r_d;
  logic [RGB_BITS-1:0] g_q, g_d;
  logic [RGB_BITS-1:0] b_q, b_d;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (!en) begin
      h_d = '0;
      v_d = '0;
    end else if (h_q == H_LAST_L) begin
      h_d = '0;
      v_d = (v_q == V_LAST_L) ? '0 : v_q + 1'b1;
    end else begin
      h_d = h_q + 1'b1;
    end
  end

  always_comb begin
    active        = en && (h_q < H_ACT_L) && (v_q < V_ACT_L);
    fetch_req_d   = active;
    fetch_x_d     = active ? h_q : '0;
    fetch_y_d     = active ? v_q : '0;
    frame_start_d = active && (h_q == '0) && (v_q == '0);
    line_start_d  = active && (h_q == '0);
    vblank_d      = en && (v_q >= V_ACT_L);
  end

  // ctl_q[0] is the fetch-stage copy; ctl_q[FETCH_LAT] lines up with the returning pixel.
  always_comb begin
    ctl_d[0].den = active;
    ctl_d[0].hs  = en && (h_q >= H_SS_L) && (h_q < H_SE_L);
    ctl_d[0].vs  = en && (v_q >= V_SS_L) && (v_q < V_SE_L);
    for (int i = 1; i <= FETCH_LAT; i++) begin
      ctl_d[i] = ctl_q[i-1];
    end
  end

  always_comb begin
    tap     = ctl_q[FETCH_LAT];
    den_d   = tap.den;
    hsync_d = tap.hs ? H_POL : ~H_POL;
    vsync_d = tap.vs ? V_POL : ~V_POL;
    r_d     = tap.den ? pix_r : '0;
    g_d     = tap.den ? pix_g : '0;
    b_d     = tap.den ? pix_b : '0;
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      h_q           <= '0;
      v_q           <= '0;
      fetch_req_q   <= 1'b0;
      fetch_x_q     <= '0;
      fetch_y_q     <= '0;
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
      vblank_q      <= 1'b0;
      for (int i = 0; i <= FETCH_LAT; i++) begin
        ctl_q[i] <= '0;
      end
      den_q   <= 1'b0;
      hsync_q <= ~H_POL;
      vsync_q <= ~V_POL;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      fetch_req_q   <= fetch_req_d;
      fetch_x_q     <= fetch_x_d;
      fetch_y_q     <= fetch_y_d;
      frame_start_q <= frame_start_d;
      line_start_q  <= line_start_d;
      vblank_q      <= vblank_d;
      for (int i = 0; i <= FETCH_LAT; i++) begin
        ctl_q[i] <= ctl_d[i];
      end
      den_q   <= den_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
    end
  end

  assign fetch_req   = fetch_req_q;
  assign fetch_x     = fetch_x_q;
  assign fetch_y     = fetch_y_q;
  assign frame_start = frame_start_q;
  assign line_start  = line_start_q;
  assign vblank      = vblank_q;
  assign den         = den_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign r           = r_q;
  assign g           = g_q;
  assign b           = b_q;

endmodule
